// File: rtl/offset_field_packer_if.sv
// rtl/offset_field_packer_if.sv - request/result handshake bundle for the offset field packer
interface offset_field_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] target;
    logic [15:0] pc;
    logic        mode;
    logic [1:0]  width_sel;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] field;
    logic        range_err;

    modport master (
        output in_valid, target, pc, mode, width_sel, out_ready,
        input  in_ready, out_valid, field, range_err
    );

    modport slave (
        input  in_valid, target, pc, mode, width_sel, out_ready,
        output in_ready, out_valid, field, range_err
    );
endinterface

// File: rtl/offset_field_packer.sv
// rtl/offset_field_packer.sv - packs a 16-bit value or PC-relative offset into a narrow signed field
module offset_field_packer #(
    parameter int          ERR_CNT_W = 8,
    parameter logic [15:0] PC_INC    = 16'd1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    offset_field_packer_if.slave bus,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic                 s1_valid;
    logic [15:0]          s1_v;
    logic [1:0]           s1_wsel;

    logic                 out_valid_q;
    logic [10:0]          field_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic                 s2_load;
    logic                 out_fire;
    logic [15:0]          v_next;
    logic [10:0]          pack_field;
    logic                 pack_err;

    // S2 frees up when empty or when its result is being taken this cycle
    assign s2_load      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_load;
    assign out_fire     = out_valid_q && bus.out_ready;

    // PC-relative offsets are taken against the incremented PC, modulo 2^16
    assign v_next = bus.mode ? (bus.target - (bus.pc + PC_INC)) : bus.target;

    assign bus.out_valid = out_valid_q;
    assign bus.field     = field_q;
    assign bus.range_err = err_q;
    assign err_count     = err_cnt_q;

    // Truncate to the selected width; representable only if bits [15:N-1] are all sign copies
    always_comb begin
        pack_field = '0;
        pack_err   = 1'b0;
        case (s1_wsel)
            2'b00: begin
                pack_field = {6'd0, s1_v[4:0]};
                pack_err   = !((&s1_v[15:4]) || !(|s1_v[15:4]));
            end
            2'b01: begin
                pack_field = {5'd0, s1_v[5:0]};
                pack_err   = !((&s1_v[15:5]) || !(|s1_v[15:5]));
            end
            2'b10: begin
                pack_field = {2'd0, s1_v[8:0]};
                pack_err   = !((&s1_v[15:8]) || !(|s1_v[15:8]));
            end
            default: begin
                pack_field = s1_v[10:0];
                pack_err   = !((&s1_v[15:10]) || !(|s1_v[15:10]));
            end
        endcase
    end

    // Stage 1: capture the full-width value and the width select on input transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_v     <= '0;
            s1_wsel  <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_v    <= v_next;
                s1_wsel <= bus.width_sel;
            end
        end
    end

    // Stage 2: output registers, held stable while the consumer stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            field_q     <= '0;
            err_q       <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                field_q <= pack_field;
                err_q   <= pack_err;
            end
        end
    end

    // Saturating count of delivered out-of-range results; clear takes priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else if (err_clr) begin
            err_cnt_q <= '0;
        end else if (out_fire && err_q && (err_cnt_q != ERR_MAX)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_offset_field_packer.sv
// tb/tb_offset_field_packer.sv - self-checking bench for offset_field_packer
module tb_offset_field_packer;

    localparam int ERR_CNT_W = 8;
    localparam int PC_INC    = 1;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 err_clr = 1'b0;
    logic [ERR_CNT_W-1:0] err_count;

    offset_field_packer_if bus();

    offset_field_packer #(
        .ERR_CNT_W(ERR_CNT_W),
        .PC_INC   (16'(PC_INC))
    ) dut (
        .clk      (clk),
        .reset_n  (rst_n),
        .bus      (bus),
        .err_clr  (err_clr),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] target;
        logic [15:0] pc;
        logic        mode;
        logic [1:0]  wsel;
        logic [10:0] field;
        logic        err;
    } vec_t;

    typedef struct {
        logic [10:0] f;
        logic        e;
    } exp_t;

    vec_t tbl [16];
    exp_t exp_q [$];
    exp_t mon_e;
    int   pop_cyc [$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   exp_cnt = 0;
    logic rnd_done = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: signed range check on the wrapped 16-bit value, low N bits kept
    task automatic model(input logic [15:0] t, input logic [15:0] p, input logic m,
                         input logic [1:0] w, output logic [10:0] f, output logic e);
        int n;
        int v;
        n = (w == 2'd0) ? 5 : (w == 2'd1) ? 6 : (w == 2'd2) ? 9 : 11;
        v = m ? (int'(t) - int'(p) - PC_INC) : int'(t);
        v = ((v % 65536) + 65536) % 65536;
        if (v >= 32768) v = v - 65536;
        e = (v < -(1 << (n - 1))) || (v > (1 << (n - 1)) - 1);
        f = 11'(v & ((1 << n) - 1));
    endtask

    // Called just after a rising edge; returns just after the edge on which it transferred
    task automatic send(input logic [15:0] t, input logic [15:0] p, input logic m,
                        input logic [1:0] w, input logic [10:0] ef, input logic ee);
        int   k;
        logic ok;
        exp_t x;
        bus.in_valid  = 1'b1;
        bus.target    = t;
        bus.pc        = p;
        bus.mode      = m;
        bus.width_sel = w;
        k  = 0;
        ok = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            k++;
            if (k >= 1000) break;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready 0 for %0d cycles, required 1", k);
            bus.in_valid = 1'b0;
        end else begin
            x.f = ef;
            x.e = ee;
            exp_q.push_back(x);
            n_acc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_model(input logic [15:0] t, input logic [15:0] p, input logic m,
                              input logic [1:0] w);
        logic [10:0] f;
        logic        e;
        model(t, p, m, w, f, e);
        send(t, p, m, w, f, e);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        bus.in_valid = 1'b0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Result scoreboard and error-count reference, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got field 0x%0h, required no result", bus.field);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result_field", 32'(bus.field), 32'(mon_e.f));
                chk("result_err", 32'(bus.range_err), 32'(mon_e.e));
                pop_cyc.push_back(cyc);
                if (!err_clr && mon_e.e && exp_cnt < CNT_MAX) exp_cnt++;
            end
        end
        if (rst_n && err_clr) exp_cnt = 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t, p;
        logic        m;
        logic [1:0]  w;
        int          off;
        int          n_tbl_err;
        int          acc0;
        int          sz;
        logic        stale;

        tbl[0]  = '{16'h3101, 16'h3000, 1'b1, 2'd2, 11'h100, 1'b1};
        tbl[1]  = '{16'h3101, 16'h3000, 1'b1, 2'd3, 11'h100, 1'b0};
        tbl[2]  = '{16'h2F01, 16'h3000, 1'b1, 2'd2, 11'h100, 1'b0};
        tbl[3]  = '{16'h2F00, 16'h3000, 1'b1, 2'd2, 11'h0FF, 1'b1};
        tbl[4]  = '{16'hFFF0, 16'h0000, 1'b0, 2'd0, 11'h010, 1'b0};
        tbl[5]  = '{16'h0010, 16'h0000, 1'b0, 2'd0, 11'h010, 1'b1};
        tbl[6]  = '{16'h0000, 16'hFFFF, 1'b1, 2'd0, 11'h000, 1'b0};
        tbl[7]  = '{16'h000F, 16'h0000, 1'b0, 2'd0, 11'h00F, 1'b0};
        tbl[8]  = '{16'h001F, 16'h0000, 1'b0, 2'd1, 11'h01F, 1'b0};
        tbl[9]  = '{16'h0020, 16'h0000, 1'b0, 2'd1, 11'h020, 1'b1};
        tbl[10] = '{16'hFFE0, 16'h0000, 1'b0, 2'd1, 11'h020, 1'b0};
        tbl[11] = '{16'h03FF, 16'h0000, 1'b0, 2'd3, 11'h3FF, 1'b0};
        tbl[12] = '{16'h0400, 16'h0000, 1'b0, 2'd3, 11'h400, 1'b1};
        tbl[13] = '{16'hFC00, 16'h0000, 1'b0, 2'd3, 11'h400, 1'b0};
        tbl[14] = '{16'h00FF, 16'h0000, 1'b0, 2'd2, 11'h0FF, 1'b0};
        tbl[15] = '{16'h0100, 16'h0000, 1'b0, 2'd2, 11'h100, 1'b1};

        bus.in_valid  = 1'b0;
        bus.target    = '0;
        bus.pc        = '0;
        bus.mode      = 1'b0;
        bus.width_sel = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_field", 32'(bus.field), 32'd0);
        chk("reset_range_err", 32'(bus.range_err), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: result visible one edge after the S1 capture edge
        send(16'h0005, 16'h0000, 1'b0, 2'd0, 11'h005, 1'b0);
        bus.in_valid = 1'b0;
        chk("latency_s1_only", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
        chk("latency_field", 32'(bus.field), 32'h005);
        idle(3);

        // Directed table, streamed back-to-back
        n_tbl_err = 0;
        for (int i = 0; i < 16; i++) begin
            send(tbl[i].target, tbl[i].pc, tbl[i].mode, tbl[i].wsel, tbl[i].field, tbl[i].err);
            if (tbl[i].err) n_tbl_err++;
        end
        wait_drain("table_drain");
        chk("table_err_count", 32'(err_count), 32'(n_tbl_err));

        // Random traffic with random consumer stalls
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    p = 16'($urandom);
                    m = 1'($urandom_range(0, 1));
                    w = 2'($urandom_range(0, 3));
                    if ($urandom_range(0, 2) != 0) begin
                        off = int'($urandom_range(0, 2400)) - 1200;
                        t   = m ? 16'(int'(p) + PC_INC + off) : 16'(off);
                    end else begin
                        t = 16'($urandom);
                    end
                    send_model(t, p, m, w);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                bus.in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                for (int k = 0; k < 20000; k++) begin
                    if (rnd_done && exp_q.size() == 0) break;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("random_drain");
        chk("random_err_count", 32'(err_count), 32'(exp_cnt));

        // Standalone clear
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("clear_err_count", 32'(err_count), 32'd0);

        // Saturation
        for (int i = 0; i < 260; i++) send(16'h0010, 16'h0000, 1'b0, 2'd0, 11'h010, 1'b1);
        wait_drain("sat_drain");
        chk("sat_err_count", 32'(err_count), 32'(CNT_MAX));

        // Clear on the same edge as an error transfer
        bus.out_ready = 1'b0;
        send(16'h0010, 16'h0000, 1'b0, 2'd0, 11'h010, 1'b1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_race_held", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("clr_race_err_count", 32'(err_count), 32'd0);
        chk("clr_race_consumed", 32'(bus.out_valid), 32'd0);

        // Backpressure: two entries fill, then a gap-free drain in order
        bus.out_ready = 1'b0;
        acc0 = n_acc;
        fork
            begin
                send_model(16'h0001, 16'h0000, 1'b0, 2'd0);
                send_model(16'h0020, 16'h0000, 1'b0, 2'd0);
                send_model(16'h0003, 16'h0000, 1'b0, 2'd0);
                send_model(16'h0004, 16'h0000, 1'b0, 2'd0);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                chk("bp_accepted", 32'(n_acc - acc0), 32'd2);
                chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
                chk("bp_first_field", 32'(bus.field), 32'h001);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("bp_drain");
        sz = pop_cyc.size();
        chk("bp_no_gaps", 32'(pop_cyc[sz-1] - pop_cyc[sz-4]), 32'd3);

        // Asynchronous reset with two entries in flight
        send(16'h0010, 16'h0000, 1'b0, 2'd0, 11'h010, 1'b1);
        wait_drain("rst_pre_drain");
        chk("rst_pre_err_count", 32'(err_count), 32'(exp_cnt));
        bus.out_ready = 1'b0;
        send(16'h0011, 16'h0000, 1'b0, 2'd0, 11'h011, 1'b1);
        send(16'h0012, 16'h0000, 1'b0, 2'd0, 11'h012, 1'b1);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_async_err_count", 32'(err_count), 32'd0);
        exp_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", 32'(bus.in_ready), 32'd1);
        stale = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        chk("rst_no_stale", 32'(stale), 32'd0);
        @(posedge clk);
        #1;
        send_model(16'h3050, 16'h3000, 1'b1, 2'd1);
        wait_drain("rst_post_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/offset_field_packer.md
Name: offset_field_packer

Overview:
- Inverse of the datapath sign extenders: takes a full 16-bit value and packs it into a narrow two's-complement instruction field of 5, 6, 9 or 11 bits.
- Reports when the value is not representable in that field.
- Optional PC-relative mode computes Target - (PC+1) first.
- Used by the on-chip instruction builder/loader feeding memory. Two-stage valid/ready pipeline with a saturating range-error counter.

Parameters:
- ERR_CNT_W, 8, width of saturating range-error counter
- PC_INC, 1, constant added to PC before the offset subtraction (LC-3 incremented-PC semantics)

Ports:
- Clk  input  1  clock, all state on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- In_Valid  input  1  request present
- In_Ready  output  1  packer accepts request this cycle
- Target  input  16  immediate value (Mode=0) or target address (Mode=1)
- PC  input  16  current instruction address (used only when Mode=1)
- Mode  input  1  0 = raw immediate, 1 = PC-relative offset
- Width_Sel  input  2  00 = 5-bit (imm5), 01 = 6-bit (offset6), 10 = 9-bit (PCoffset9), 11 = 11-bit (PCoffset11)
- Out_Valid  output  1  result present
- Out_Ready  input  1  consumer accepts result
- Field  output  11  packed field, right-justified; bits above selected width are 0
- Range_Err  output  1  value not representable in selected width
- Err_Clr  input  1  synchronous clear of Err_Count
- Err_Count  output  ERR_CNT_W  saturating count of delivered results with Range_Err=1

Behaviour:
- Reset (Reset_n=0, async):
  - Both stage valids cleared.
  - Out_Valid=0, Field=0, Range_Err=0, Err_Count=0.
  - In_Ready=1 once reset is released.
  - In-flight requests are discarded, not completed.
- Handshake:
  - A transfer occurs on an edge where Valid and Ready are both 1.
  - Producer holds Target/PC/Mode/Width_Sel stable while In_Valid=1 and In_Ready=0.
  - Out_Valid, once high, stays high with Field/Range_Err stable until Out_Ready=1.
- Stage 1 (S1): on input transfer, register V = Target (Mode=0) or V = Target - (PC + PC_INC) mod 2^16 (Mode=1). Also register Width_Sel.
- Stage 2 (S2 = output regs):
  - Field = V[N-1:0], where N = 5/6/9/11.
  - Range_Err = 1 iff V[15:N-1] is not all-equal, i.e. V is outside [-2^(N-1), 2^(N-1)-1].
  - On error Field still carries the truncated V[N-1:0].
- Advance rules:
  - S2 loads when S2 is empty or Out_Ready=1.
  - S1 loads when S1 is empty or S1 moves into S2.
  - In_Ready = !S1_valid || S2_load (combinational path from Out_Ready permitted).
- Latency: 2 cycles from input transfer to Out_Valid with no backpressure. Throughput 1 result/cycle sustained.
- Backpressure:
  - With Out_Ready=0, the pipeline holds at most 2 entries. In_Ready drops when both stages are full.
  - No entry is lost or duplicated; order is preserved.
- Err_Count:
  - Increments by 1 on each output transfer with Range_Err=1.
  - Saturates at 2^ERR_CNT_W-1 (255); no wrap.
  - Err_Clr=1 sets it to 0 on the next edge. Clear wins over a simultaneous increment (result 0).
- Arithmetic is modulo 2^16: PC=0xFFFF, Target=0x0000, Mode=1 gives V=0x0000 (PC+1 wraps).
- Invariant: when Range_Err=0, sign-extending Field[N-1:0] to 16 bits reproduces V exactly.

Test Plan:
- Mode=1, PC=0x3000, Target=0x3101, Width_Sel=10 -> V=0x0100, Range_Err=1, Field=0x100. Repeat with Width_Sel=11 -> Range_Err=0, Field=0x100.
- Mode=1, PC=0x3000, Target=0x2F01, Width_Sel=10 -> V=0xFF00 (-256), Field=0x100, Range_Err=0. Target=0x2F00 -> Range_Err=1.
- Mode=0, Target=0xFFF0, Width_Sel=00 -> Field=0x010, Range_Err=0. Target=0x0010 -> Field=0x010, Range_Err=1, Err_Count=1 after the transfer.
- Backpressure:
  - Stream 4 requests with Out_Ready=0 -> In_Ready falls after 2 accepted, Out_Valid=1 holding the first result.
  - Release Out_Ready -> all 4 results emerge in order, one per cycle, with no gaps once flowing.
- Saturation: 260 consecutive error results -> Err_Count stops at 255. Err_Clr asserted on the same edge as an error transfer -> Err_Count=0.
- Reset: assert Reset_n=0 mid-stream with 2 entries in flight -> Out_Valid=0 and Err_Count=0 immediately (async). After release, In_Ready=1 and no stale result appears.
